// File: rtl/bpi_flash_responder.sv
// BPI flash target model: latched word address, strobed writes, fixed-latency reads.
// Optional sticky protocol-error detection is enabled by defining BPI_RESP_ERR_EN.
module bpi_flash_responder #(
  parameter int AW     = 6,
  parameter int DW     = 16,
  parameter int RD_LAT = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          E,
  input  logic          L,
  input  logic          W,
  input  logic          G,
  input  logic [22:0]   ADDR,
  input  logic [DW-1:0] DIN,
  output logic [DW-1:0] DOUT,
  output logic          DOUT_VLD,
  output logic          BUSY,
  output logic          ERR
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WR,
    S_RD_WAIT,
    S_RD_DATA
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] addr_q;
  logic [2:0]    cnt, cnt_n;
  logic [DW-1:0] din_q;
  logic [DW-1:0] mem [DEPTH];
  logic          ld_addr, cap_din, do_wr, rd_fire, vld_n;
  logic          addr_unused;

  // Upper address bits are accepted from the bus but do not select storage.
  assign addr_unused = ^ADDR[22:AW];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ld_addr = 1'b0;
    cap_din = 1'b0;
    do_wr   = 1'b0;
    rd_fire = 1'b0;
    vld_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (E && L) begin
          ld_addr = 1'b1;
          state_n = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!E) begin
          state_n = S_IDLE;
        end else if (L) begin
          ld_addr = 1'b1;
        end else if (W) begin
          cap_din = 1'b1;
          state_n = S_WR;
        end else if (G) begin
          cnt_n   = 3'd1;
          state_n = S_RD_WAIT;
        end
      end
      S_WR: begin
        // Commit happens on W release regardless of E, so a write is never lost.
        if (!W) begin
          do_wr   = 1'b1;
          state_n = E ? S_ADDR : S_IDLE;
        end else if (E) begin
          cap_din = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (!E) begin
          state_n = S_IDLE;
        end else if (!G) begin
          state_n = S_ADDR;
        end else if (cnt == 3'(RD_LAT)) begin
          rd_fire = 1'b1;
          vld_n   = 1'b1;
          state_n = S_RD_DATA;
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      S_RD_DATA: begin
        if (!E) begin
          state_n = S_IDLE;
        end else if (!G) begin
          state_n = S_ADDR;
        end else begin
          rd_fire = 1'b1;
          vld_n   = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      cnt      <= '0;
      din_q    <= '0;
      DOUT     <= '0;
      DOUT_VLD <= 1'b0;
      BUSY     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      DOUT_VLD <= vld_n;
      BUSY     <= (state_n != S_IDLE);
      if (ld_addr) addr_q <= ADDR[AW-1:0];
      if (cap_din) din_q <= DIN;
      if (do_wr) mem[addr_q] <= din_q;
      if (rd_fire) DOUT <= mem[addr_q];
    end
  end

`ifdef BPI_RESP_ERR_EN
  logic err_hit;

  assign err_hit = E && ((G && W) || ((state == S_IDLE) && (W || G)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR <= 1'b0;
    end else if (err_hit) begin
      ERR <= 1'b1;
    end
  end
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_bpi_flash_responder.sv
// Directed/random bench for bpi_flash_responder against a word-array reference model.
module tb_bpi_flash_responder;

  localparam int AW     = 6;
  localparam int DW     = 16;
  localparam int RD_LAT = 3;

  logic          CLK = 1'b0;
  logic          RST, E, L, W, G;
  logic [22:0]   ADDR;
  logic [DW-1:0] DIN;
  logic [DW-1:0] DOUT;
  logic          DOUT_VLD, BUSY, ERR;

  int n_checks = 0;
  int n_fails  = 0;

  logic [DW-1:0] mdl [1<<AW];
  logic [DW-1:0] last_dout;
  logic          err_exp;

  bpi_flash_responder #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .RST(RST), .E(E), .L(L), .W(W), .G(G),
    .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT), .DOUT_VLD(DOUT_VLD),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < (1 << AW); i++) mdl[i] = '0;
    last_dout = '0;
    err_exp   = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int nw,
                          input bit l_in_wr);
    E = 1; L = 1; ADDR = 23'(a); tick();
    chk("wr_busy_addr", 32'(BUSY), 32'd1);
    L = 0; W = 1;
    for (int i = 0; i < nw; i++) begin
      DIN = (i == nw - 1) ? d : ~d;
      if (l_in_wr && i == 1) begin
        L = 1; ADDR = 23'(a ^ 6'h15);
      end else begin
        L = 0;
      end
      tick();
    end
    L = 0; W = 0; E = 0; DIN = $urandom;
    tick();
    chk("wr_busy_done", 32'(BUSY), 32'd0);
    chk("wr_no_vld", 32'(DOUT_VLD), 32'd0);
    mdl[a] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int ng);
    bit vexp;
    E = 1; L = 1; ADDR = 23'(a); tick();
    L = 0; G = 1;
    for (int i = 1; i <= ng; i++) begin
      tick();
      vexp = (i >= RD_LAT + 1);
      if (vexp) last_dout = mdl[a];
      chk($sformatf("rd_vld_g%0d", i), 32'(DOUT_VLD), 32'(vexp));
      chk($sformatf("rd_dout_g%0d", i), 32'(DOUT), 32'(last_dout));
      chk("rd_busy", 32'(BUSY), 32'd1);
    end
    G = 0; tick();
    chk("rd_vld_drop", 32'(DOUT_VLD), 32'd0);
    chk("rd_dout_hold", 32'(DOUT), 32'(last_dout));
    chk("rd_busy_addr", 32'(BUSY), 32'd1);
    E = 0; tick();
    chk("rd_busy_idle", 32'(BUSY), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    RST = 1; E = 0; L = 0; W = 0; G = 0; ADDR = '0; DIN = '0;
    mdl_reset();
    tick(); tick();
    RST = 0;
    chk("rst_dout", 32'(DOUT), 32'd0);
    chk("rst_vld", 32'(DOUT_VLD), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);

    do_read(6'h3F, 4);
    do_write(6'd5, 16'hA5A5, 2, 1'b0);
    do_read(6'd5, 5);
    do_read(6'd5, 2);

    for (int k = 0; k < 10; k++) begin
      ra = AW'($urandom);
      rd = DW'($urandom);
      do_write(ra, rd, 1 + int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      do_read(ra, 2 + int'($urandom_range(0, 4)));
      do_read(AW'($urandom), 4 + int'($urandom_range(0, 2)));
    end

`ifdef BPI_RESP_ERR_EN
    err_exp = 1'b1;
`endif
    E = 1; G = 1; tick();
    chk("err_set", 32'(ERR), 32'(err_exp));
    E = 0; G = 0; tick(); tick();
    chk("err_sticky", 32'(ERR), 32'(err_exp));
    chk("err_idle_busy", 32'(BUSY), 32'd0);

    E = 1; L = 1; ADDR = 23'd9; tick();
    L = 0; W = 1; G = 1; DIN = 16'h5A3C; tick();
    chk("wg_busy", 32'(BUSY), 32'd1);
    chk("wg_no_vld", 32'(DOUT_VLD), 32'd0);
    G = 0; tick();
    W = 0; E = 0; tick();
    mdl[9] = 16'h5A3C;
    do_read(6'd9, 4);

    E = 1; L = 1; ADDR = 23'd7; tick();
    L = 0; W = 1; DIN = 16'h1234; tick();
    RST = 1; tick();
    RST = 0; W = 0; E = 0; tick();
    mdl_reset();
    chk("rst_wr_busy", 32'(BUSY), 32'd0);
    chk("rst_wr_dout", 32'(DOUT), 32'd0);
    chk("rst_wr_err", 32'(ERR), 32'd0);
    do_read(6'd7, 4);
    do_read(6'd9, 4);

    for (int k = 0; k < 6; k++) begin
      ra = AW'($urandom);
      rd = DW'($urandom);
      do_write(ra, rd, 1 + int'($urandom_range(0, 2)), 1'b1);
      do_read(ra, 4 + int'($urandom_range(0, 2)));
    end
    chk("final_err", 32'(ERR), 32'(err_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
